// File: rtl/rv32m_pkg.sv
// RV32M shared definitions: multiply/divide funct3[1:0] encodings.
// Imported by decode, the multiply sequencer and the divider.
package rv32m_pkg;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

endpackage

// File: rtl/mul_result_stage_if.sv
// Issue and result handshake channels of the multiply sequencer.
// slave = the sequencer, master = issue logic plus writeback consumer.
interface mul_result_stage_if #(
    parameter int TAG_W = 5
);

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag,
        input  out_ready,
        output in_ready,
        output out_valid, out_result, out_tag
    );

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag,
        output out_ready,
        input  in_ready,
        input  out_valid, out_result, out_tag
    );

endinterface

// File: rtl/mul_result_stage.sv
// Two-stage RV32M multiply sequencer around an external signed
// 32x32 multiplier: operand stage (S1) then result stage (S2).
module mul_result_stage
    import rv32m_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    mul_result_stage_if.slave io,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_product,
    output logic        busy
);

    logic             s1_valid_q, s1_valid_d;
    logic [1:0]       op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [TAG_W-1:0] tag_q;

    logic             out_valid_q, out_valid_d;
    logic [31:0]      result_q, result_d;
    logic [TAG_W-1:0] otag_q;

    logic s1_adv;
    logic accept;

    // Turns the signed*signed high word into the mixed/unsigned one.
    function automatic logic [31:0] hi_correct(
        input logic [1:0]  op,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] hi
    );
        logic [31:0] r;
        r = hi;
        case (op)
            OP_MULHSU: r = hi + (b[31] ? a : 32'd0);
            OP_MULHU:  r = hi + (b[31] ? a : 32'd0)
                              + (a[31] ? b : 32'd0);
            default:   r = hi;
        endcase
        return r;
    endfunction

    always_comb begin
        s1_adv      = s1_valid_q & (~out_valid_q | io.out_ready);
        io.in_ready = ~flush & (~s1_valid_q | s1_adv);
        accept      = io.in_valid & io.in_ready;
        s1_valid_d  = accept | (s1_valid_q & ~s1_adv);
        out_valid_d = s1_adv | (out_valid_q & ~io.out_ready);
        if (op_q == OP_MUL) begin
            result_d = mul_product[31:0];
        end else begin
            result_d = hi_correct(op_q, a_q, b_q, mul_product[63:32]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            op_q        <= 2'b00;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            tag_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= 32'd0;
            otag_q      <= '0;
        end else if (flush) begin
            // Data regs keep stale values; only the valids are killed.
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            if (accept) begin
                op_q  <= io.in_op;
                a_q   <= io.in_a;
                b_q   <= io.in_b;
                tag_q <= io.in_tag;
            end
            if (s1_adv) begin
                result_q <= result_d;
                otag_q   <= tag_q;
            end
        end
    end

    assign mul_a         = a_q;
    assign mul_b         = b_q;
    assign io.out_valid  = out_valid_q;
    assign io.out_result = result_q;
    assign io.out_tag    = otag_q;
    assign busy          = s1_valid_q | out_valid_q;

endmodule

// File: tb/tb_mul_result_stage.sv
// Randomised bench for mul_result_stage against a queue-based
// model of RV32M multiply semantics.
module tb_mul_result_stage;

    localparam int TAG_W = 5;

    typedef struct {
        logic [1:0]       op;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
        logic [31:0]      want;
    } op_t;

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        int               acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_product;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    op_t  pend[$];
    exp_t exp_q[$];

    mul_result_stage_if #(.TAG_W(TAG_W)) io ();

    mul_result_stage #(.TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .io          (io),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_product (mul_product),
        .busy        (busy)
    );

    // External signed multiplier
    assign mul_product = 64'($signed(mul_a)) * 64'($signed(mul_b));

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(
        input logic [1:0] op, input logic [31:0] a, input logic [31:0] b
    );
        logic [63:0] p;
        logic [63:0] sa, sb, ua, ub;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'b00: begin p = sa * sb; return p[31:0]; end
            2'b01: begin p = sa * sb; return p[63:32]; end
            2'b10: begin p = sa * ub; return p[63:32]; end
            default: begin p = ua * ub; return p[63:32]; end
        endcase
    endfunction

    function automatic op_t rand_op(input logic [TAG_W-1:0] tag);
        op_t o;
        o.op  = 2'($urandom_range(3));
        case ($urandom_range(3))
            0: o.a = 32'h8000_0000;
            1: o.a = 32'hFFFF_FFFF;
            default: o.a = $urandom;
        endcase
        o.b   = ($urandom_range(3) == 0) ? 32'hFFFF_FFFF : $urandom;
        o.tag = tag;
        o.want = ref_result(o.op, o.a, o.b);
        return o;
    endfunction

    // ready_mode: 0 always ready, 1 random, 2 low for 3 cycles then high
    task automatic run_stream(input int ready_mode, input int gap_pct);
        int          iter = 0;
        bit          prev_stall = 1'b0;
        logic [31:0] prev_res = '0;
        logic [TAG_W-1:0] prev_tag = '0;
        logic        exp_rdy, exp_ov;
        exp_t        e;
        while ((pend.size() > 0 || exp_q.size() > 0) && iter < 600) begin
            @(negedge clk);
            if (pend.size() > 0 && $urandom_range(99) >= gap_pct) begin
                io.in_valid = 1'b1;
                io.in_op  = pend[0].op;
                io.in_a   = pend[0].a;
                io.in_b   = pend[0].b;
                io.in_tag = pend[0].tag;
            end else begin
                io.in_valid = 1'b0;
                io.in_op  = 2'($urandom_range(3));
                io.in_a   = $urandom;
                io.in_b   = $urandom;
                io.in_tag = TAG_W'($urandom);
            end
            case (ready_mode)
                0: io.out_ready = 1'b1;
                1: io.out_ready = 1'($urandom_range(1));
                default: io.out_ready = (iter >= 3);
            endcase
            #1;
            exp_rdy = !(exp_q.size() == 2 && !io.out_ready);
            n_checks++;
            if (io.in_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL in_ready iter=%0d got=%b want=%b",
                         iter, io.in_ready, exp_rdy);
            end
            exp_ov = (exp_q.size() > 0) && (exp_q[0].acc <= iter - 2);
            n_checks++;
            if (io.out_valid !== exp_ov) begin
                n_fail++;
                $display("FAIL out_valid iter=%0d got=%b want=%b",
                         iter, io.out_valid, exp_ov);
            end
            if (prev_stall && io.out_valid) begin
                n_checks++;
                if (io.out_result !== prev_res || io.out_tag !== prev_tag) begin
                    n_fail++;
                    $display("FAIL stall_hold got=%h/%0d want=%h/%0d",
                             io.out_result, io.out_tag, prev_res, prev_tag);
                end
            end
            if (io.out_valid && io.out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL spurious_out got tag=%0d want none",
                             io.out_tag);
                end else begin
                    e = exp_q.pop_front();
                    if (io.out_result !== e.res || io.out_tag !== e.tag) begin
                        n_fail++;
                        $display("FAIL result got=%h tag=%0d want=%h tag=%0d",
                                 io.out_result, io.out_tag, e.res, e.tag);
                    end
                end
            end
            prev_stall = io.out_valid && !io.out_ready;
            prev_res   = io.out_result;
            prev_tag   = io.out_tag;
            if (io.in_valid && io.in_ready) begin
                e.res = pend[0].want;
                e.tag = pend[0].tag;
                e.acc = iter;
                exp_q.push_back(e);
                void'(pend.pop_front());
            end
            iter++;
        end
        n_checks++;
        if (iter >= 600) begin
            n_fail++;
            $display("FAIL stream_timeout got=%0d pending want 0",
                     pend.size() + exp_q.size());
            pend.delete();
            exp_q.delete();
        end
        @(negedge clk);
        io.in_valid = 1'b0;
    endtask

    task automatic fill_two(input logic [TAG_W-1:0] t0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            io.in_valid  = 1'b1;
            io.in_op     = 2'($urandom_range(3));
            io.in_a      = $urandom;
            io.in_b      = $urandom;
            io.in_tag    = t0 + TAG_W'(i);
            io.out_ready = 1'b0;
        end
        @(negedge clk);
        io.in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (io.out_valid !== 1'b0 || busy !== 1'b0 ||
            io.out_result !== 32'd0 || io.out_tag !== '0) begin
            n_fail++;
            $display("FAIL reset_out got v=%b b=%b r=%h t=%0d want 0",
                     io.out_valid, busy, io.out_result, io.out_tag);
        end
        n_checks++;
        if (mul_a !== 32'd0 || mul_b !== 32'd0 || io.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mul got a=%h b=%h rdy=%b want 0 0 1",
                     mul_a, mul_b, io.in_ready);
        end
    endtask

    task automatic push_dir(input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] w,
                            input logic [TAG_W-1:0] tag);
        op_t o;
        o.op = op; o.a = a; o.b = b; o.tag = tag; o.want = w;
        pend.push_back(o);
    endtask

    task automatic test_directed;
        push_dir(2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 5'd10);
        push_dir(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 5'd11);
        push_dir(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd12);
        push_dir(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13);
        push_dir(2'b10, 32'd2, 32'h8000_0000, 32'h0000_0001, 5'd14);
        run_stream(0, 60);
    endtask

    task automatic test_back_to_back;
        for (int t = 1; t <= 4; t++) pend.push_back(rand_op(TAG_W'(t)));
        run_stream(2, 0);
    endtask

    task automatic test_random;
        for (int t = 0; t < 60; t++) pend.push_back(rand_op(TAG_W'(t)));
        run_stream(1, 30);
        for (int t = 0; t < 30; t++) pend.push_back(rand_op(TAG_W'(t)));
        run_stream(0, 0);
    endtask

    task automatic test_flush;
        fill_two(5'd20);
        @(negedge clk);
        flush       = 1'b1;
        io.in_valid = 1'b1;
        io.in_tag   = 5'd25;
        #1;
        n_checks++;
        if (io.in_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_cycle got rdy=%b busy=%b want 0 1",
                     io.in_ready, busy);
        end
        @(negedge clk);
        flush       = 1'b0;
        io.in_valid = 1'b0;
        #1;
        n_checks++;
        if (io.out_valid !== 1'b0 || busy !== 1'b0 || io.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_after got v=%b busy=%b rdy=%b want 0 0 1",
                     io.out_valid, busy, io.in_ready);
        end
        pend.push_back(rand_op(5'd26));
        run_stream(0, 0);
    endtask

    task automatic test_async_reset;
        fill_two(5'd28);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (io.out_valid !== 1'b0 || busy !== 1'b0 ||
            io.out_result !== 32'd0 || io.out_tag !== '0 ||
            mul_a !== 32'd0 || mul_b !== 32'd0) begin
            n_fail++;
            $display("FAIL async_rst got v=%b busy=%b r=%h t=%0d a=%h b=%h want 0",
                     io.out_valid, busy, io.out_result, io.out_tag, mul_a, mul_b);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (io.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_release_ready got=%b want=1", io.in_ready);
        end
        pend.push_back(rand_op(5'd31));
        run_stream(0, 0);
    endtask

    initial begin
        io.in_valid  = 1'b0;
        io.in_op     = 2'b00;
        io.in_a      = 32'd0;
        io.in_b      = 32'd0;
        io.in_tag    = '0;
        io.out_ready = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
